// File: rtl/alu_ctrl.sv
// Command-side initiator for the 4-bit ALU: accepts register-to-register commands,
// issues one ALU cycle from an internal register file, writes back and responds.
module alu_ctrl #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_load_i,
    input  logic [3:0]               cmd_op_i,
    input  logic [$clog2(NREGS)-1:0] cmd_rd_i,
    input  logic [$clog2(NREGS)-1:0] cmd_rs1_i,
    input  logic [$clog2(NREGS)-1:0] cmd_rs2_i,
    input  logic [WIDTH-1:0]         cmd_imm_i,
    output logic [WIDTH-1:0]         alu_a_o,
    output logic [WIDTH-1:0]         alu_b_o,
    output logic [3:0]               alu_op_o,
    input  logic [WIDTH-1:0]         alu_result_i,
    input  logic                     alu_invalid_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [WIDTH-1:0]         rsp_data_o,
    output logic                     rsp_err_o
);
    localparam int RW = $clog2(NREGS);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic            load;
        logic [3:0]      op;
        logic [RW-1:0]   rd;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [WIDTH-1:0] imm;
    } cmd_t;

    state_t           state_q, state_d;
    cmd_t             cmd_q;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             issue_err;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid_i) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outcome of the ISSUE cycle; on an invalid opcode wr_data stays 0, which is also the response data.
    always_comb begin
        wr_en     = 1'b0;
        wr_data   = '0;
        issue_err = 1'b0;
        if (cmd_q.load) begin
            wr_en   = 1'b1;
            wr_data = cmd_q.imm;
        end else if (alu_invalid_i) begin
            issue_err = 1'b1;
        end else begin
            wr_en   = 1'b1;
            wr_data = alu_result_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cmd_valid_i) begin
                cmd_q <= '{load: cmd_load_i, op: cmd_op_i, rd: cmd_rd_i,
                           rs1: cmd_rs1_i, rs2: cmd_rs2_i, imm: cmd_imm_i};
            end
            if (state_q == ISSUE) begin
                rsp_data_q <= wr_data;
                rsp_err_q  <= issue_err;
            end
        end
    end

    // Operands are read combinationally during ISSUE, so a write to rs1/rs2 lands after the read.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (state_q == ISSUE && wr_en) begin
            regs_q[cmd_q.rd] <= wr_data;
        end
    end

    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = '0;
        if (state_q == ISSUE && !cmd_q.load) begin
            alu_a_o  = regs_q[cmd_q.rs1];
            alu_b_o  = regs_q[cmd_q.rs2];
            alu_op_o = cmd_q.op;
        end
    end

    // Ready is masked by reset so every output reads 0 while reset is held.
    assign cmd_ready_o = rstn_i && (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: a behavioural ALU drives the result ports, and a register-array
// model predicts every response under directed and random command streams.
module tb_alu_ctrl;
    localparam int WIDTH = 4;
    localparam int NREGS = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_load = 1'b0;
    logic [3:0]       cmd_op = '0;
    logic [1:0]       cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [3:0]       cmd_imm = '0;
    logic [3:0]       alu_a, alu_b, alu_op, alu_result;
    logic             alu_invalid;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [3:0]       rsp_data;
    logic             rsp_err;

    int               n_chk = 0;
    int               n_fail = 0;
    logic [3:0]       mdl_regs [NREGS];
    time              acc_time;

    always #5 clk = ~clk;

    alu_ctrl #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_load_i(cmd_load), .cmd_op_i(cmd_op),
        .cmd_rd_i(cmd_rd), .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2), .cmd_imm_i(cmd_imm),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_result_i(alu_result), .alu_invalid_i(alu_invalid),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err)
    );

    // ALU used by this bench: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not a, 6 pass a, 7 negate a.
    function automatic logic [4:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic       inv;
        inv = 1'b0;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = ~a;
            4'd6:    r = a;
            4'd7:    r = ~a + 4'd1;
            default: begin r = 4'd0; inv = 1'b1; end
        endcase
        return {inv, r};
    endfunction

    assign {alu_invalid, alu_result} = alu_f(alu_op, alu_a, alu_b);

    task automatic mdl_reset();
        for (int i = 0; i < NREGS; i++) mdl_regs[i] = 4'd0;
    endtask

    task automatic mdl_exec(input logic ld, input logic [3:0] op, input logic [1:0] rd,
                            input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm,
                            output logic [3:0] d, output logic e);
        logic [4:0] r;
        if (ld) begin
            mdl_regs[rd] = imm; d = imm; e = 1'b0;
        end else begin
            r = alu_f(op, mdl_regs[rs1], mdl_regs[rs2]);
            if (r[4]) begin
                d = 4'd0; e = 1'b1;
            end else begin
                mdl_regs[rd] = r[3:0]; d = r[3:0]; e = 1'b0;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the response handshake.
    // lat counts negedges after the accepting edge until rsp_valid is seen (99 = never accepted).
    task automatic do_cmd(input logic ld, input logic [3:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm,
                          output logic [3:0] d, output logic e, output int lat);
        int w;
        cmd_load = ld; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        w = 0;
        while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
        @(posedge clk);
        acc_time = $time;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        if (w >= 20) lat = 99;
        d = rsp_data; e = rsp_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #3;
        n_chk++; if ({alu_a, alu_b, alu_op} !== 12'h000) begin n_fail++; $display("FAIL reset_alu_ports got=%h exp=000", {alu_a, alu_b, alu_op}); end
        n_chk++; if ({rsp_valid, rsp_err, rsp_data} !== 6'd0) begin n_fail++; $display("FAIL reset_rsp got=%b exp=000000", {rsp_valid, rsp_err, rsp_data}); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        mdl_reset();
        #1;
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        @(negedge clk);
    endtask

    task automatic test_load_add();
        logic [3:0] d, ed; logic e, ee; int lat;
        mdl_exec(1, 0, 0, 0, 0, 3, ed, ee); do_cmd(1, 0, 0, 0, 0, 3, d, e, lat);
        n_chk++; if (d !== 4'd3 || e !== 1'b0) begin n_fail++; $display("FAIL load_r0 got=%h/%b exp=3/0", d, e); end
        mdl_exec(1, 0, 1, 0, 0, 5, ed, ee); do_cmd(1, 0, 1, 0, 0, 5, d, e, lat);
        n_chk++; if (d !== ed || e !== ee) begin n_fail++; $display("FAIL load_r1 got=%h/%b exp=%h/%b", d, e, ed, ee); end
        mdl_exec(0, 0, 2, 0, 1, 0, ed, ee); do_cmd(0, 0, 2, 0, 1, 0, d, e, lat);
        n_chk++; if (d !== 4'd8 || d !== ed || e !== 1'b0) begin n_fail++; $display("FAIL add_3_5 got=%h/%b exp=8/0", d, e); end
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_wrap();
        logic [3:0] d, ed; logic e, ee; int lat;
        mdl_exec(0, 1, 3, 0, 1, 0, ed, ee); do_cmd(0, 1, 3, 0, 1, 0, d, e, lat);
        n_chk++; if (d !== 4'hE || d !== ed || e !== 1'b0) begin n_fail++; $display("FAIL sub_wrap got=%h/%b exp=e/0", d, e); end
        mdl_exec(0, 7, 3, 0, 0, 0, ed, ee); do_cmd(0, 7, 3, 0, 0, 0, d, e, lat);
        n_chk++; if (d !== 4'hD || d !== ed || e !== 1'b0) begin n_fail++; $display("FAIL neg_r0 got=%h/%b exp=d/0", d, e); end
    endtask

    task automatic test_invalid();
        logic [3:0] d, ed; logic e, ee; int lat;
        mdl_exec(1, 0, 2, 0, 0, 8, ed, ee); do_cmd(1, 0, 2, 0, 0, 8, d, e, lat);
        mdl_exec(0, 4'hB, 2, 0, 1, 0, ed, ee); do_cmd(0, 4'hB, 2, 0, 1, 0, d, e, lat);
        n_chk++; if (d !== 4'd0 || e !== 1'b1 || ee !== 1'b1) begin n_fail++; $display("FAIL invalid_op got=%h/%b exp=0/1", d, e); end
        mdl_exec(0, 6, 2, 2, 2, 0, ed, ee); do_cmd(0, 6, 2, 2, 2, 0, d, e, lat);
        n_chk++; if (d !== 4'd8 || d !== ed) begin n_fail++; $display("FAIL invalid_no_write got=%h exp=8", d); end
    endtask

    task automatic test_alu_ports();
        logic [3:0] d, ed; logic e, ee;
        cmd_load = 0; cmd_op = 4'd4; cmd_rd = 0; cmd_rs1 = 1; cmd_rs2 = 2; cmd_imm = 0;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++; if ({alu_a, alu_b, alu_op} !== {mdl_regs[1], mdl_regs[2], 4'd4}) begin
            n_fail++; $display("FAIL issue_ports got=%h exp=%h", {alu_a, alu_b, alu_op}, {mdl_regs[1], mdl_regs[2], 4'd4}); end
        mdl_exec(0, 4, 0, 1, 2, 0, ed, ee);
        @(negedge clk);
        n_chk++; if ({alu_a, alu_b, alu_op} !== 12'h000) begin n_fail++; $display("FAIL resp_ports got=%h exp=000", {alu_a, alu_b, alu_op}); end
        n_chk++; if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_err !== ee) begin
            n_fail++; $display("FAIL xor_rsp got=%b/%h/%b exp=1/%h/%b", rsp_valid, rsp_data, rsp_err, ed, ee); end
        @(posedge clk); @(negedge clk);
        cmd_load = 1; cmd_op = 4'd3; cmd_rd = 1; cmd_imm = 4'd5; cmd_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++; if ({alu_a, alu_b, alu_op} !== 12'h000) begin n_fail++; $display("FAIL load_ports got=%h exp=000", {alu_a, alu_b, alu_op}); end
        mdl_exec(1, 3, 1, 1, 2, 5, ed, ee);
        @(negedge clk); @(posedge clk); @(negedge clk);
    endtask

    task automatic test_stall();
        logic [3:0] ed, ed2, held; logic ee, ee2; int w;
        cmd_load = 0; cmd_op = 4'd0; cmd_rd = 1; cmd_rs1 = 0; cmd_rs2 = 1; cmd_imm = 0;
        cmd_valid = 1'b1; rsp_ready = 1'b0;
        mdl_exec(0, 0, 1, 0, 1, 0, ed, ee);
        @(posedge clk); @(negedge clk);
        cmd_load = 1; cmd_rd = 3; cmd_imm = 4'd9;
        @(negedge clk);
        held = rsp_data;
        n_chk++; if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_err !== ee) begin
            n_fail++; $display("FAIL stall_first got=%b/%h exp=1/%h", rsp_valid, rsp_data, ed); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++; if (rsp_valid !== 1'b1 || rsp_data !== held || rsp_err !== ee || cmd_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d got=%b/%h/%b/%b exp=1/%h/%b/0", i, rsp_valid, rsp_data, rsp_err, cmd_ready, held, ee); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_chk++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release got=%b/%b exp=0/1", rsp_valid, cmd_ready); end
        mdl_exec(1, 0, 3, 0, 1, 9, ed2, ee2);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_next_accept got=%b exp=0", cmd_ready); end
        w = 0;
        while (!rsp_valid && w < 20) begin @(negedge clk); w++; end
        n_chk++; if (rsp_valid !== 1'b1 || rsp_data !== ed2 || rsp_err !== ee2) begin
            n_fail++; $display("FAIL stall_second got=%b/%h exp=1/%h", rsp_valid, rsp_data, ed2); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_hazard();
        logic [3:0] d, ed; logic e, ee; int lat;
        mdl_exec(1, 0, 0, 0, 0, 7, ed, ee); do_cmd(1, 0, 0, 0, 0, 7, d, e, lat);
        mdl_exec(0, 0, 0, 0, 0, 0, ed, ee); do_cmd(0, 0, 0, 0, 0, 0, d, e, lat);
        n_chk++; if (d !== 4'hE || d !== ed) begin n_fail++; $display("FAIL hazard_first got=%h exp=e", d); end
        mdl_exec(0, 0, 0, 0, 0, 0, ed, ee); do_cmd(0, 0, 0, 0, 0, 0, d, e, lat);
        n_chk++; if (d !== 4'hC || d !== ed) begin n_fail++; $display("FAIL hazard_second got=%h exp=c", d); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d, ed; logic e, ee; int lat; time t0;
        mdl_exec(1, 0, 2, 0, 0, 4'hA, ed, ee); do_cmd(1, 0, 2, 0, 0, 4'hA, d, e, lat);
        t0 = acc_time;
        mdl_exec(0, 2, 1, 2, 0, 0, ed, ee); do_cmd(0, 2, 1, 2, 0, 0, d, e, lat);
        n_chk++; if (acc_time - t0 !== 30) begin n_fail++; $display("FAIL throughput got=%0t exp=30", acc_time - t0); end
        n_chk++; if (d !== ed || e !== ee) begin n_fail++; $display("FAIL b2b_and got=%h/%b exp=%h/%b", d, e, ed, ee); end
    endtask

    task automatic test_random();
        logic [3:0] d, ed, op, imm; logic e, ee, ld; logic [1:0] rd, rs1, rs2; int lat;
        for (int i = 0; i < 40; i++) begin
            ld  = ($urandom_range(0, 2) == 0);
            op  = 4'($urandom_range(0, 9));
            rd  = 2'($urandom_range(0, 3));
            rs1 = 2'($urandom_range(0, 3));
            rs2 = 2'($urandom_range(0, 3));
            imm = 4'($urandom_range(0, 15));
            mdl_exec(ld, op, rd, rs1, rs2, imm, ed, ee);
            do_cmd(ld, op, rd, rs1, rs2, imm, d, e, lat);
            n_chk++; if (d !== ed || e !== ee || lat !== 2) begin
                n_fail++; $display("FAIL random%0d ld=%b op=%h got=%h/%b/%0d exp=%h/%b/2", i, ld, op, d, e, lat, ed, ee); end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] d; logic e; int lat, seen;
        cmd_load = 0; cmd_op = 4'd3; cmd_rd = 3; cmd_rs1 = 1; cmd_rs2 = 2;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        rstn = 1'b0;
        #1;
        n_chk++; if ({alu_a, alu_b, alu_op, rsp_data} !== 16'h0000 || {rsp_valid, rsp_err, cmd_ready} !== 3'b000) begin
            n_fail++; $display("FAIL midreset_outputs got=%h/%b exp=0000/000", {alu_a, alu_b, alu_op, rsp_data}, {rsp_valid, rsp_err, cmd_ready}); end
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        mdl_reset();
        seen = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (rsp_valid) seen++; end
        n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_rsp got=%0d exp=0", seen); end
        for (int r = 0; r < NREGS; r++) begin
            do_cmd(0, 6, 2'(r), 2'(r), 2'(r), 0, d, e, lat);
            n_chk++; if (d !== mdl_regs[r] || e !== 1'b0) begin n_fail++; $display("FAIL midreset_r%0d got=%h exp=%h", r, d, mdl_regs[r]); end
        end
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_wrap();
        test_invalid();
        test_alu_ports();
        test_stall();
        test_hazard();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
